// File: rtl/sc_fifo_showahead_if.sv
// Handshake bundle between a FIFO producer/consumer and sc_fifo_showahead.
// The master side drives requests and data; the slave side (the FIFO) returns head data and status.
interface sc_fifo_showahead_if #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 4
);
  logic                   sclr;
  logic                   wrreq;
  logic [WIDTH-1:0]       data;
  logic                   rdreq;
  logic [WIDTH-1:0]       q;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic [$clog2(SIZE):0]  usedw;

  modport master (
    output sclr, wrreq, data, rdreq,
    input  q, empty, full, almost_empty, almost_full, usedw
  );

  modport slave (
    input  sclr, wrreq, data, rdreq,
    output q, empty, full, almost_empty, almost_full, usedw
  );
endinterface

// File: rtl/sc_fifo_showahead.sv
// Single-clock show-ahead FIFO: the head entry is always presented on q with no read latency.
// Flags and usedw are decoded from the registered entry count.
module sc_fifo_showahead #(
  parameter int WIDTH              = 64,
  parameter int SIZE               = 4,
  parameter int ALMOST_FULL_VALUE  = 4,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  sc_fifo_showahead_if.slave      bus
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]    head_reg, head_next;
  logic [AW-1:0]    tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             wr_en;
  logic             rd_en;

  // Requests against a full/empty FIFO are dropped regardless of the opposite request.
  assign wr_en = bus.wrreq & ~bus.full  & ~bus.sclr;
  assign rd_en = bus.rdreq & ~bus.empty & ~bus.sclr;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (bus.sclr) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (wr_en) tail_next = tail_reg + AW'(1);
      if (rd_en) head_next = head_reg + AW'(1);
      if (wr_en && !rd_en)
        count_next = count_reg + CW'(1);
      else if (rd_en && !wr_en)
        count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage has no reset; stale contents are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_reg] <= bus.data;
  end

  assign bus.q            = mem[head_reg];
  assign bus.usedw        = count_reg;
  assign bus.empty        = (count_reg == '0);
  assign bus.full         = (count_reg == CW'(SIZE));
  assign bus.almost_empty = (count_reg <  CW'(ALMOST_EMPTY_VALUE));
  assign bus.almost_full  = (count_reg >= CW'(ALMOST_FULL_VALUE));
endmodule

// File: tb/tb_sc_fifo_showahead.sv
// Directed bench for sc_fifo_showahead (WIDTH=64, SIZE=4, AF=4, AE=2).
// A table of per-cycle vectors with hand-computed expectations, plus reset sequences.
module tb_sc_fifo_showahead;
  logic clk;
  logic reset;
  int   tests;
  int   failures;

  sc_fifo_showahead_if #(.WIDTH(64), .SIZE(4)) bus ();

  sc_fifo_showahead #(
    .WIDTH(64), .SIZE(4), .ALMOST_FULL_VALUE(4), .ALMOST_EMPTY_VALUE(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sclr;
    logic        wrreq;
    logic        rdreq;
    logic [63:0] data;
    logic        chk_q;
    logic [63:0] q;
    logic [2:0]  usedw;
    logic        empty;
    logic        full;
    logic        ae;
    logic        af;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic sclr, logic wrreq, logic rdreq,
                              logic [63:0] data, logic chk_q, logic [63:0] q,
                              logic [2:0] usedw, logic empty, logic full,
                              logic ae, logic af);
    vec_t v;
    v.name = name; v.sclr = sclr; v.wrreq = wrreq; v.rdreq = rdreq; v.data = data;
    v.chk_q = chk_q; v.q = q; v.usedw = usedw; v.empty = empty; v.full = full;
    v.ae = ae; v.af = af;
    return v;
  endfunction

  task automatic check(string name, logic chk_q, logic [63:0] eq, logic [2:0] eu,
                       logic ee, logic ef, logic eae, logic eaf);
    tests++;
    if (bus.usedw !== eu || bus.empty !== ee || bus.full !== ef ||
        bus.almost_empty !== eae || bus.almost_full !== eaf ||
        (chk_q && bus.q !== eq)) begin
      failures++;
      $display("FAIL %s: got usedw=%0d empty=%b full=%b ae=%b af=%b q=%h, want usedw=%0d empty=%b full=%b ae=%b af=%b q=%h%s",
               name, bus.usedw, bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.q,
               eu, ee, ef, eae, eaf, eq, chk_q ? "" : "(q unchecked)");
    end else begin
      $display("[TB] ok   %s usedw=%0d q=%h", name, bus.usedw, bus.q);
    end
  endtask

  task automatic idle_inputs();
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();

    // Fill, overflow attempt, drain, underflow attempt
    vecs.push_back(mk("fill0",   0,1,0, 64'hA0, 1,64'hA0, 3'd1, 0,0,1,0));
    vecs.push_back(mk("fill1",   0,1,0, 64'hA1, 1,64'hA0, 3'd2, 0,0,0,0));
    vecs.push_back(mk("fill2",   0,1,0, 64'hA2, 1,64'hA0, 3'd3, 0,0,0,0));
    vecs.push_back(mk("fill3",   0,1,0, 64'hA3, 1,64'hA0, 3'd4, 0,1,0,1));
    vecs.push_back(mk("ovf",     0,1,0, 64'hFF, 1,64'hA0, 3'd4, 0,1,0,1));
    vecs.push_back(mk("drain0",  0,0,1, 64'h0,  1,64'hA1, 3'd3, 0,0,0,0));
    vecs.push_back(mk("drain1",  0,0,1, 64'h0,  1,64'hA2, 3'd2, 0,0,0,0));
    vecs.push_back(mk("drain2",  0,0,1, 64'h0,  1,64'hA3, 3'd1, 0,0,1,0));
    vecs.push_back(mk("drain3",  0,0,1, 64'h0,  0,64'h0,  3'd0, 1,0,1,0));
    vecs.push_back(mk("udf",     0,0,1, 64'h0,  0,64'h0,  3'd0, 1,0,1,0));
    // rd+wr on empty: only the write takes effect
    vecs.push_back(mk("rdwr_empty", 0,1,1, 64'h10, 1,64'h10, 3'd1, 0,0,1,0));
    vecs.push_back(mk("pre_wrap",   0,1,0, 64'h11, 1,64'h10, 3'd2, 0,0,0,0));
    // 10 concurrent rd+wr cycles holding two entries, crossing the pointer wrap
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk($sformatf("wrap%0d", k), 0,1,1, 64'h12 + 64'(k),
                        1, 64'h11 + 64'(k), 3'd2, 0,0,0,0));
    vecs.push_back(mk("refill0", 0,1,0, 64'h1C, 1,64'h1A, 3'd3, 0,0,0,0));
    vecs.push_back(mk("refill1", 0,1,0, 64'h1D, 1,64'h1A, 3'd4, 0,1,0,1));
    // full with rd+wr: only the read happens
    vecs.push_back(mk("full_rdwr", 0,1,1, 64'h99, 1,64'h1B, 3'd3, 0,0,0,0));
    vecs.push_back(mk("pop_1B",    0,0,1, 64'h0,  1,64'h1C, 3'd2, 0,0,0,0));
    vecs.push_back(mk("pop_1C",    0,0,1, 64'h0,  1,64'h1D, 3'd1, 0,0,1,0));
    // count=1 rd+wr: old popped, new one shown next
    vecs.push_back(mk("one_rdwr",  0,1,1, 64'h77, 1,64'h77, 3'd1, 0,0,1,0));
    vecs.push_back(mk("pre_clr0",  0,1,0, 64'h20, 1,64'h77, 3'd2, 0,0,0,0));
    vecs.push_back(mk("pre_clr1",  0,1,0, 64'h21, 1,64'h77, 3'd3, 0,0,0,0));
    vecs.push_back(mk("sclr",      1,1,1, 64'hEE, 0,64'h0,  3'd0, 1,0,1,0));
    vecs.push_back(mk("post_clr",  0,1,0, 64'h55, 1,64'h55, 3'd1, 0,0,1,0));

    // Reset state before any clock edge
    #2;
    check("reset_init", 0, 64'h0, 3'd0, 1,0,1,0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      bus.sclr  = vecs[i].sclr;
      bus.wrreq = vecs[i].wrreq;
      bus.rdreq = vecs[i].rdreq;
      bus.data  = vecs[i].data;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].chk_q, vecs[i].q, vecs[i].usedw,
            vecs[i].empty, vecs[i].full, vecs[i].ae, vecs[i].af);
    end
    idle_inputs();

    // Async reset mid-cycle with one entry held
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 0, 64'h0, 3'd0, 1,0,1,0);
    bus.wrreq = 1'b1;
    bus.data  = 64'hDD;
    @(posedge clk);
    #1;
    check("write_in_reset", 0, 64'h0, 3'd0, 1,0,1,0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("after_reset", 0, 64'h0, 3'd0, 1,0,1,0);
    bus.wrreq = 1'b1;
    bus.data  = 64'h42;
    @(posedge clk);
    #1;
    check("write_after_reset", 1, 64'h42, 3'd1, 0,0,1,0);
    idle_inputs();
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
